// File: rtl/pipeline_ctrl_pkg.sv
// Shared codes, stall masks and state encoding for the pipeline sequencer.
package pipeline_ctrl_pkg;

   localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
   localparam logic [31:0] EXC_INT     = 32'h0000_0001;
   localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
   localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
   localparam logic [31:0] EXC_OV      = 32'h0000_000c;
   localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
   localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_IF   = 6'b000011;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PEND  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   function automatic logic [31:0] redirect_pc(
      input logic [31:0] code,
      input logic [31:0] epc,
      input logic [31:0] vec
   );
      return (code == EXC_ERET) ? epc : vec;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_watchdog.sv
// Saturating stall watchdog with a sticky error flag.
module ctrl_watchdog #(
   parameter int LIMIT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic err
);

   localparam int W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] MAX = W'(LIMIT);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         err <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && cnt != MAX) begin
         cnt <= cnt + 1'b1;
         if (cnt == MAX - 1'b1)
            err <= 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stall merge, deferred exception flush, stall statistics.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        exc_ack,
   output logic [31:0] stall_cycles,
   output logic        timeout_err
);

   state_t      state;
   logic [31:0] code_q;
   logic [31:0] epc_q;
   logic        bus_busy;
   logic        exc_in;
   logic        any_req;
   logic        wd_inc;

   assign bus_busy = stallreq_if | stallreq_mem;
   assign exc_in   = excepttype_i != EXC_NONE;
   assign any_req  = stallreq_if | stallreq_id
                   | stallreq_ex | stallreq_mem;
   assign wd_inc   = any_req | (state == ST_PEND);

   // Stall must act in the same cycle the request appears.
   always_comb begin
      stall = STALL_NONE;
      if (!rst) begin
         unique case (state)
            ST_PEND:  stall = STALL_MEM;
            ST_FLUSH: stall = STALL_NONE;
            default: begin
               if (exc_in)            stall = STALL_MEM;
               else if (stallreq_mem) stall = STALL_MEM;
               else if (stallreq_ex)  stall = STALL_EX;
               else if (stallreq_id)  stall = STALL_ID;
               else if (stallreq_if)  stall = STALL_IF;
               else                   stall = STALL_NONE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         flush        <= 1'b0;
         exc_ack      <= 1'b0;
         new_pc       <= '0;
         code_q       <= '0;
         epc_q        <= '0;
         stall_cycles <= '0;
      end else begin
         flush   <= 1'b0;
         exc_ack <= 1'b0;
         new_pc  <= '0;
         if (stall[0] == STOP)
            stall_cycles <= stall_cycles + 32'd1;
         unique case (state)
            ST_IDLE: begin
               if (exc_in) begin
                  code_q <= excepttype_i;
                  epc_q  <= cp0_epc_i;
                  if (bus_busy) begin
                     state <= ST_PEND;
                  end else begin
                     state   <= ST_FLUSH;
                     flush   <= 1'b1;
                     exc_ack <= 1'b1;
                     new_pc  <= redirect_pc(excepttype_i,
                                            cp0_epc_i,
                                            EXC_VECTOR);
                  end
               end
            end
            ST_PEND: begin
               if (!bus_busy) begin
                  state   <= ST_FLUSH;
                  flush   <= 1'b1;
                  exc_ack <= 1'b1;
                  new_pc  <= redirect_pc(code_q, epc_q, EXC_VECTOR);
               end
            end
            ST_FLUSH: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   ctrl_watchdog #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk(clk),
      .rst(rst),
      .inc(wd_inc),
      .clr(!wd_inc),
      .err(timeout_err)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a short watchdog limit.
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_if;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic [31:0] excepttype_i;
   logic [31:0] cp0_epc_i;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        exc_ack;
   logic [31:0] stall_cycles;
   logic        timeout_err;

   int passed = 0;
   int total  = 0;

   pipeline_ctrl #(
      .EXC_VECTOR(32'h0000_0020),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .stallreq_if(stallreq_if),
      .stallreq_id(stallreq_id),
      .stallreq_ex(stallreq_ex),
      .stallreq_mem(stallreq_mem),
      .excepttype_i(excepttype_i),
      .cp0_epc_i(cp0_epc_i),
      .stall(stall),
      .flush(flush),
      .new_pc(new_pc),
      .exc_ack(exc_ack),
      .stall_cycles(stall_cycles),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      stallreq_if  = 1'b0;
      stallreq_id  = 1'b0;
      stallreq_ex  = 1'b0;
      stallreq_mem = 1'b0;
      excepttype_i = 32'h0;
      cp0_epc_i    = 32'h0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      mid();
      total++;
      if (stall !== 6'b000000 || flush !== 1'b0 || exc_ack !== 1'b0) begin
         $display("FAIL reset_ctl stall=%b flush=%b ack=%b want 000000/0/0", stall, flush, exc_ack);
      end else passed++;
      total++;
      if (new_pc !== 32'h0 || stall_cycles !== 32'h0 || timeout_err !== 1'b0) begin
         $display("FAIL reset_val new_pc=%h sc=%0d to=%b want 0/0/0", new_pc, stall_cycles, timeout_err);
      end else passed++;
   endtask

   task automatic test_stall_priority();
      cyc();
      stallreq_id = 1'b1;
      stallreq_ex = 1'b1;
      mid();
      total++;
      if (stall !== 6'b001111) begin
         $display("FAIL prio_id_ex stall=%b want 001111", stall);
      end else passed++;
      cyc();
      clear_inputs();
      stallreq_if = 1'b1;
      mid();
      total++;
      if (stall !== 6'b000011) begin
         $display("FAIL prio_if stall=%b want 000011", stall);
      end else passed++;
      cyc();
      stallreq_mem = 1'b1;
      stallreq_id  = 1'b1;
      mid();
      total++;
      if (stall !== 6'b011111) begin
         $display("FAIL prio_mem stall=%b want 011111", stall);
      end else passed++;
      cyc();
      clear_inputs();
      mid();
      total++;
      if (stall !== 6'b000000) begin
         $display("FAIL prio_none stall=%b want 000000", stall);
      end else passed++;
   endtask

   task automatic test_exception();
      cyc();
      excepttype_i = 32'h8;
      stallreq_ex  = 1'b1;
      mid();
      total++;
      if (stall !== 6'b011111 || flush !== 1'b0) begin
         $display("FAIL exc_t stall=%b flush=%b want 011111/0", stall, flush);
      end else passed++;
      cyc();
      clear_inputs();
      mid();
      total++;
      if (flush !== 1'b1 || exc_ack !== 1'b1 || new_pc !== 32'h20 || stall !== 6'b0) begin
         $display("FAIL exc_flush flush=%b ack=%b pc=%h stall=%b want 1/1/00000020/000000", flush, exc_ack, new_pc, stall);
      end else passed++;
      cyc();
      mid();
      total++;
      if (flush !== 1'b0 || exc_ack !== 1'b0 || new_pc !== 32'h0) begin
         $display("FAIL exc_after flush=%b ack=%b pc=%h want 0/0/0", flush, exc_ack, new_pc);
      end else passed++;
   endtask

   task automatic test_eret();
      cyc();
      excepttype_i = 32'he;
      cp0_epc_i    = 32'h0000_1234;
      cyc();
      clear_inputs();
      mid();
      total++;
      if (flush !== 1'b1 || new_pc !== 32'h0000_1234) begin
         $display("FAIL eret flush=%b pc=%h want 1/00001234", flush, new_pc);
      end else passed++;
   endtask

   task automatic test_deferred();
      cyc();
      stallreq_mem = 1'b1;
      excepttype_i = 32'hc;
      cp0_epc_i    = 32'h5555;
      mid();
      total++;
      if (stall !== 6'b011111) begin
         $display("FAIL pend_entry stall=%b want 011111", stall);
      end else passed++;
      cyc();
      excepttype_i = 32'h0;
      cp0_epc_i    = 32'h9999;
      repeat (3) cyc();
      mid();
      total++;
      if (stall !== 6'b011111 || flush !== 1'b0) begin
         $display("FAIL pend_hold stall=%b flush=%b want 011111/0", stall, flush);
      end else passed++;
      cyc();
      stallreq_mem = 1'b0;
      mid();
      total++;
      if (stall !== 6'b011111 || flush !== 1'b0) begin
         $display("FAIL pend_fall stall=%b flush=%b want 011111/0", stall, flush);
      end else passed++;
      cyc();
      mid();
      total++;
      if (flush !== 1'b1 || exc_ack !== 1'b1 || new_pc !== 32'h20) begin
         $display("FAIL pend_flush flush=%b ack=%b pc=%h want 1/1/00000020", flush, exc_ack, new_pc);
      end else passed++;
      cyc();
      clear_inputs();
      stallreq_if  = 1'b1;
      excepttype_i = 32'he;
      cp0_epc_i    = 32'h0000_0100;
      cyc();
      excepttype_i = 32'h0;
      cp0_epc_i    = 32'h0000_0200;
      cyc();
      stallreq_if = 1'b0;
      cyc();
      mid();
      total++;
      if (flush !== 1'b1 || new_pc !== 32'h0000_0100) begin
         $display("FAIL pend_epc flush=%b pc=%h want 1/00000100", flush, new_pc);
      end else passed++;
      cyc();
      clear_inputs();
   endtask

   task automatic test_timeout();
      do_reset();
      stallreq_ex = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      stallreq_ex = 1'b0;
      cyc();
      cyc();
      mid();
      total++;
      if (timeout_err !== 1'b0) begin
         $display("FAIL timeout_7 to=%b want 0", timeout_err);
      end else passed++;
      stallreq_ex = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      stallreq_ex = 1'b0;
      mid();
      total++;
      if (timeout_err !== 1'b1) begin
         $display("FAIL timeout_8 to=%b want 1", timeout_err);
      end else passed++;
      repeat (3) cyc();
      mid();
      total++;
      if (timeout_err !== 1'b1) begin
         $display("FAIL timeout_sticky to=%b want 1", timeout_err);
      end else passed++;
   endtask

   task automatic test_reset_mid_pend();
      do_reset();
      stallreq_if = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      stallreq_if = 1'b0;
      mid();
      total++;
      if (stall_cycles !== 32'd3) begin
         $display("FAIL stall_count sc=%0d want 3", stall_cycles);
      end else passed++;
      cyc();
      stallreq_mem = 1'b1;
      excepttype_i = 32'h8;
      cyc();
      excepttype_i = 32'h0;
      cyc();
      clear_inputs();
      rst = 1'b1;
      mid();
      total++;
      if (stall !== 6'b000000) begin
         $display("FAIL rst_pend_stall stall=%b want 000000", stall);
      end else passed++;
      cyc();
      rst = 1'b0;
      mid();
      total++;
      if (stall !== 6'b0 || flush !== 1'b0 || exc_ack !== 1'b0 || new_pc !== 32'h0 || stall_cycles !== 32'h0) begin
         $display("FAIL rst_pend_out stall=%b flush=%b ack=%b pc=%h sc=%0d want all 0", stall, flush, exc_ack, new_pc, stall_cycles);
      end else passed++;
      cyc();
      mid();
      total++;
      if (flush !== 1'b0 || exc_ack !== 1'b0 || stall !== 6'b0) begin
         $display("FAIL rst_pend_noflush flush=%b ack=%b stall=%b want 0/0/000000", flush, exc_ack, stall);
      end else passed++;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      test_reset();
      test_stall_priority();
      test_exception();
      test_eret();
      test_deferred();
      test_timeout();
      test_reset_mid_pend();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
